uart_rx_frame_chk: RTL and testbench

//  Parametrised UART RX frame checker. Successor to the single-bit start checker.

---
 rtl/uart_rx_frame_chk_if.sv | 42 ++++
 rtl/uart_rx_frame_chk.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame_chk.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_chk_if.sv
// Sampler-to-frame-checker bus for uart_rx_frame_chk.
// The error-counter signals exist only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_frame_chk_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
);
  logic                  FRAME_START;
  logic                  BIT_VALID;
  logic                  SAMPLED_BIT;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  BUSY;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VLD;
  logic                  STRT_ERR;
  logic                  PAR_ERR;
  logic                  STOP_ERR;
`ifdef UART_RX_ERR_CNT_EN
  logic                     CNT_CLR;
  logic [ERR_CNT_WIDTH-1:0] STRT_ERR_CNT;
  logic [ERR_CNT_WIDTH-1:0] PAR_ERR_CNT;
  logic [ERR_CNT_WIDTH-1:0] STOP_ERR_CNT;
`endif

  modport master (
    output FRAME_START, BIT_VALID, SAMPLED_BIT, PAR_EN, PAR_TYP,
`ifdef UART_RX_ERR_CNT_EN
    output CNT_CLR,
    input  STRT_ERR_CNT, PAR_ERR_CNT, STOP_ERR_CNT,
`endif
    input  BUSY, P_DATA, DATA_VLD, STRT_ERR, PAR_ERR, STOP_ERR
  );

  modport slave (
    input  FRAME_START, BIT_VALID, SAMPLED_BIT, PAR_EN, PAR_TYP,
`ifdef UART_RX_ERR_CNT_EN
    input  CNT_CLR,
    output STRT_ERR_CNT, PAR_ERR_CNT, STOP_ERR_CNT,
`endif
    output BUSY, P_DATA, DATA_VLD, STRT_ERR, PAR_ERR, STOP_ERR
  );
endinterface

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker: validates start/parity/stop, assembles LSB-first data.
// Optional saturating per-flag error counters are enabled by UART_RX_ERR_CNT_EN.
module uart_rx_frame_chk #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input logic             CLK,
  input logic             RST,
  uart_rx_frame_chk_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  strt_err_q, strt_err_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    data_vld_d = 1'b0;
    strt_err_d = strt_err_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    unique case (state_q)
      S_IDLE: begin
        // FRAME_START wins over a same-cycle BIT_VALID, which IDLE never consumes.
        if (bus.FRAME_START) begin
          state_d    = S_START;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          strt_err_d = 1'b0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      S_START: begin
        if (bus.BIT_VALID) begin
          strt_err_d = bus.SAMPLED_BIT;
          bit_cnt_d  = '0;
          state_d    = bus.SAMPLED_BIT ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bus.BIT_VALID) begin
          shift_d   = {bus.SAMPLED_BIT, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
            stop_cnt_d = '0;
            state_d    = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bus.BIT_VALID) begin
          par_err_d  = bus.SAMPLED_BIT ^ (^shift_q) ^ par_typ_q;
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bus.BIT_VALID) begin
          stop_err_d = stop_err_q | ~bus.SAMPLED_BIT;
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (!par_err_q && !stop_err_d) begin
              data_vld_d = 1'b1;
              p_data_d   = shift_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] strt_cnt_q, strt_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] stop_cnt_err_q, stop_cnt_err_d;

  // Flags are cleared at frame entry, so a 0->1 edge counts each frame at most once.
  always_comb begin
    strt_cnt_d     = strt_cnt_q;
    par_cnt_d      = par_cnt_q;
    stop_cnt_err_d = stop_cnt_err_q;
    if (bus.CNT_CLR) begin
      strt_cnt_d     = '0;
      par_cnt_d      = '0;
      stop_cnt_err_d = '0;
    end else begin
      if (strt_err_d && !strt_err_q && !(&strt_cnt_q))
        strt_cnt_d = strt_cnt_q + 1'b1;
      if (par_err_d && !par_err_q && !(&par_cnt_q))
        par_cnt_d = par_cnt_q + 1'b1;
      if (stop_err_d && !stop_err_q && !(&stop_cnt_err_q))
        stop_cnt_err_d = stop_cnt_err_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strt_cnt_q     <= '0;
      par_cnt_q      <= '0;
      stop_cnt_err_q <= '0;
    end else begin
      strt_cnt_q     <= strt_cnt_d;
      par_cnt_q      <= par_cnt_d;
      stop_cnt_err_q <= stop_cnt_err_d;
    end
  end

  assign bus.STRT_ERR_CNT = strt_cnt_q;
  assign bus.PAR_ERR_CNT  = par_cnt_q;
  assign bus.STOP_ERR_CNT = stop_cnt_err_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      data_vld_q <= 1'b0;
      strt_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      data_vld_q <= data_vld_d;
      strt_err_q <= strt_err_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.P_DATA   = p_data_q;
  assign bus.DATA_VLD = data_vld_q;
  assign bus.STRT_ERR = strt_err_q;
  assign bus.PAR_ERR  = par_err_q;
  assign bus.STOP_ERR = stop_err_q;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Directed bench for uart_rx_frame_chk: dut1 has one stop bit, dut2 has two.
// Counter checks run only when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_frame_chk;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic frame_start = 1'b0;
  logic bit_valid   = 1'b0;
  logic sampled_bit = 1'b1;
  logic par_en      = 1'b0;
  logic par_typ     = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
  logic cnt_clr     = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_chk_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) if1 ();
  uart_rx_frame_chk_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) if2 ();

  assign if1.FRAME_START = frame_start;
  assign if1.BIT_VALID   = bit_valid;
  assign if1.SAMPLED_BIT = sampled_bit;
  assign if1.PAR_EN      = par_en;
  assign if1.PAR_TYP     = par_typ;
  assign if2.FRAME_START = frame_start;
  assign if2.BIT_VALID   = bit_valid;
  assign if2.SAMPLED_BIT = sampled_bit;
  assign if2.PAR_EN      = par_en;
  assign if2.PAR_TYP     = par_typ;
`ifdef UART_RX_ERR_CNT_EN
  assign if1.CNT_CLR = cnt_clr;
  assign if2.CNT_CLR = cnt_clr;
`endif

  uart_rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(2)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1.slave));
  uart_rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Seven idle cycles, then a one-cycle BIT_VALID: one bit every 8 cycles.
  task automatic send_bit(input logic b);
    repeat (7) tick();
    sampled_bit = b;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_busy",   32'(if1.BUSY),     32'd0);
    chk("rst_vld",    32'(if1.DATA_VLD), 32'd0);
    chk("rst_pdata",  32'(if1.P_DATA),   32'h00);
    chk("rst_errs",   32'({if1.STRT_ERR, if1.PAR_ERR, if1.STOP_ERR}), 32'd0);

    // 1: good even-parity frame 0xA5
    par_en = 1'b1; par_typ = 1'b0;
    start_frame();
    chk("t1_busy_start", 32'(if1.BUSY), 32'd1);
    send_bit(1'b0);
    send_byte(8'hA5);
    send_bit(1'b0);
    chk("t1_vld_before_stop", 32'(if1.DATA_VLD), 32'd0);
    send_bit(1'b1);
    chk("t1_vld",   32'(if1.DATA_VLD), 32'd1);
    chk("t1_pdata", 32'(if1.P_DATA),   32'hA5);
    chk("t1_errs",  32'({if1.STRT_ERR, if1.PAR_ERR, if1.STOP_ERR}), 32'd0);
    chk("t1_busy",  32'(if1.BUSY),     32'd0);
    tick();
    chk("t1_vld_pulse", 32'(if1.DATA_VLD), 32'd0);

    // 2: start bit sampled high aborts the frame
    start_frame();
    send_bit(1'b1);
    chk("t2_strt_err", 32'(if1.STRT_ERR), 32'd1);
    chk("t2_busy",     32'(if1.BUSY),     32'd0);
    chk("t2_vld",      32'(if1.DATA_VLD), 32'd0);
    send_bit(1'b0);
    chk("t2_idle_bv_ignored", 32'(if1.BUSY),     32'd0);
    chk("t2_strt_sticky",     32'(if1.STRT_ERR), 32'd1);

    // 3: odd parity expected, parity bit 0 -> parity error; FRAME_START mid-frame ignored
    par_typ = 1'b1;
    start_frame();
    chk("t3_strt_cleared", 32'(if1.STRT_ERR), 32'd0);
    chk("t3_busy",         32'(if1.BUSY),     32'd1);
    send_bit(1'b0);
    d = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        tick();
        start_frame();
        chk("t3_busy_midframe", 32'(if1.BUSY), 32'd1);
      end
      send_bit(d[i]);
    end
    send_bit(1'b0);
    chk("t3_par_err", 32'(if1.PAR_ERR), 32'd1);
    send_bit(1'b1);
    chk("t3_vld",       32'(if1.DATA_VLD), 32'd0);
    chk("t3_pdata",     32'(if1.P_DATA),   32'hA5);
    chk("t3_busy_done", 32'(if1.BUSY),     32'd0);
    tick();
    chk("t3_par_sticky", 32'(if1.PAR_ERR),  32'd1);
    chk("t3_stop_ok",    32'(if1.STOP_ERR), 32'd0);

    // 4: two stop bits (dut2), second stop low; PAR_EN toggled mid-frame
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t4_rst_busy", 32'(if2.BUSY), 32'd0);
    par_en = 1'b0; par_typ = 1'b0;
    start_frame();
    send_bit(1'b0);
    d = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) par_en = 1'b1;
      send_bit(d[i]);
    end
    send_bit(1'b1);
    chk("t4_busy_stop1", 32'(if2.BUSY),     32'd1);
    chk("t4_stop_ok1",   32'(if2.STOP_ERR), 32'd0);
    chk("t4_dut1_vld",   32'(if1.DATA_VLD), 32'd1);
    chk("t4_dut1_pdata", 32'(if1.P_DATA),   32'h3C);
    send_bit(1'b0);
    chk("t4_stop_err", 32'(if2.STOP_ERR), 32'd1);
    chk("t4_par_err",  32'(if2.PAR_ERR),  32'd0);
    chk("t4_vld",      32'(if2.DATA_VLD), 32'd0);
    chk("t4_busy",     32'(if2.BUSY),     32'd0);
    chk("t4_pdata",    32'(if2.P_DATA),   32'h00);
    par_en = 1'b0;

    // 5: reset mid-frame, then FRAME_START with same-cycle BIT_VALID and a clean 0x5A
    start_frame();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_busy",  32'(if1.BUSY),   32'd0);
    chk("t5_flags", 32'({if1.STRT_ERR, if1.PAR_ERR, if1.STOP_ERR, if1.DATA_VLD}), 32'd0);
    chk("t5_pdata", 32'(if1.P_DATA), 32'h00);
    tick();
    frame_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
    tick();
    frame_start = 1'b0; bit_valid = 1'b0;
    chk("t5_fs_wins_busy", 32'(if1.BUSY),     32'd1);
    chk("t5_fs_wins_strt", 32'(if1.STRT_ERR), 32'd0);
    send_bit(1'b0);
    send_byte(8'h5A);
    send_bit(1'b1);
    chk("t5_vld",   32'(if1.DATA_VLD), 32'd1);
    chk("t5_pdata2", 32'(if1.P_DATA),  32'h5A);

`ifdef UART_RX_ERR_CNT_EN
    // 6: 2-bit counters saturate; CNT_CLR beats a same-cycle increment
    chk("t6_cnt0", 32'(if1.STRT_ERR_CNT), 32'd0);
    for (int i = 0; i < 5; i++) begin
      start_frame();
      send_bit(1'b1);
      if (i == 1) chk("t6_cnt2", 32'(if1.STRT_ERR_CNT), 32'd2);
    end
    chk("t6_cnt_sat",  32'(if1.STRT_ERR_CNT), 32'd3);
    chk("t6_par_cnt",  32'(if1.PAR_ERR_CNT),  32'd0);
    chk("t6_stop_cnt", 32'(if1.STOP_ERR_CNT), 32'd0);
    start_frame();
    repeat (7) tick();
    sampled_bit = 1'b1; bit_valid = 1'b1; cnt_clr = 1'b1;
    tick();
    bit_valid = 1'b0; cnt_clr = 1'b0;
    chk("t6_strt_err", 32'(if1.STRT_ERR),     32'd1);
    chk("t6_cnt_clr",  32'(if1.STRT_ERR_CNT), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
